// File: rtl/tdm_pkg.sv
// Shared types and constants for the four-slot TDM receive path.
// Slot encoding matches the select lines of the companion 4:1 mux.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int SLOTS  = 4;
    localparam int MISS_W = 3;

    typedef logic [1:0]        slot_t;
    typedef logic [MISS_W-1:0] miss_t;

endpackage

// File: rtl/tdm_sync_fsm.sv
// Frame-sync flywheel: tracks the slot pointer and miss count, and issues
// capture / frame-done strobes that the datapath acts on in the same cycle.
module tdm_sync_fsm
    import tdm_pkg::*;
#(
    parameter int MISS_MAX = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  en,
    input  logic  fsync,
    output slot_t slot,
    output logic  cap,
    output slot_t cap_idx,
    output logic  frame_done,
    output logic  sync_err,
    output logic  locked
);

    state_t state, state_nxt;
    slot_t  ptr_nxt;
    miss_t  miss_cnt, miss_nxt;
    logic   err_nxt;

    // NOTE: state uses non-blocking assignments so every flop samples
    // pre-edge values; the comb block below uses blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            slot     <= '0;
            miss_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            slot     <= ptr_nxt;
            miss_cnt <= miss_nxt;
            sync_err <= err_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_nxt  = state;
        ptr_nxt    = slot;
        miss_nxt   = miss_cnt;
        cap        = 1'b0;
        cap_idx    = slot;
        frame_done = 1'b0;
        err_nxt    = 1'b0;

        if (en) begin
            unique case (state)
                HUNT: begin
                    if (fsync) begin
                        cap       = 1'b1;
                        cap_idx   = 2'd0;
                        ptr_nxt   = 2'd1;
                        miss_nxt  = '0;
                        state_nxt = LOCK;
                    end
                end
                LOCK: begin
                    if (fsync) begin
                        // A mark anywhere but slot 0 restarts the frame, even at slot 3.
                        err_nxt  = (slot != 2'd0);
                        cap      = 1'b1;
                        cap_idx  = 2'd0;
                        ptr_nxt  = 2'd1;
                        miss_nxt = '0;
                    end else if (slot == 2'd0) begin
                        err_nxt = 1'b1;
                        if (int'(miss_cnt) + 1 < MISS_MAX) begin
                            cap      = 1'b1;
                            cap_idx  = 2'd0;
                            ptr_nxt  = 2'd1;
                            miss_nxt = miss_cnt + miss_t'(1);
                        end else begin
                            miss_nxt  = '0;
                            state_nxt = HUNT;
                        end
                    end else if (slot == 2'd3) begin
                        frame_done = 1'b1;
                        ptr_nxt    = 2'd0;
                    end else begin
                        cap     = 1'b1;
                        ptr_nxt = slot + slot_t'(1);
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: shadow registers collect slots 0..2 and the
// whole frame is committed to Y0..Y3 on the edge that samples slot 3.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W        = 1,
    parameter int MISS_MAX = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in1,
    input  logic         en,
    input  logic         fsync,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic         C0,
    output logic         C1,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err
);

    slot_t        slot;
    slot_t        cap_idx;
    logic         cap;
    logic         frame_done;
    logic [W-1:0] shadow [SLOTS-1];

    tdm_sync_fsm #(
        .MISS_MAX (MISS_MAX)
    ) u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fsync      (fsync),
        .slot       (slot),
        .cap        (cap),
        .cap_idx    (cap_idx),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .locked     (locked)
    );

    // NOTE: the shadow array is reset along with the rest so a frame after
    // rst_n can never expose stale slots; it is only three words wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS - 1; i++) shadow[i] <= '0;
        end else if (cap) begin
            for (int i = 0; i < SLOTS - 1; i++) begin
                if (cap_idx == slot_t'(i)) shadow[i] <= in1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y0          <= '0;
            Y1          <= '0;
            Y2          <= '0;
            Y3          <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                Y0 <= shadow[0];
                Y1 <= shadow[1];
                Y2 <= shadow[2];
                Y3 <= in1;
            end
        end
    end

    assign C1 = slot[1];
    assign C0 = slot[0];

endmodule
